// File: rtl/decode_pipe_pkg.sv
// rtl/decode_pipe_pkg.sv - shared widths, mode encoding and default immediate table for decode_pipe.
package decode_pipe_pkg;

   localparam int DEF_IW  = 9;
   localparam int DEF_OPW = 5;
   localparam int DEF_RW  = 3;
   localparam int DEF_DW  = 8;

   typedef enum logic {
      MODE_REG = 1'b0,
      MODE_IMM = 1'b1
   } mode_e;

   localparam int OP_SETMODE = 0;

   localparam int          LUT_DEF_N = 8;
   localparam int unsigned LUT_DEFAULT [LUT_DEF_N] = '{0, 1, 4, 8, 16, 32, 64, 127};

   // Entries past the table read as zero; callers truncate to their data width.
   function automatic int unsigned lut_default(input int unsigned idx);
      if (idx < LUT_DEF_N)
         return LUT_DEFAULT[idx[2:0]];
      return 32'd0;
   endfunction

endpackage

// File: rtl/decode_pipe_imm_lut.sv
// rtl/decode_pipe_imm_lut.sv - immediate lookup table, async read, sync write, reset to defaults.
module imm_lut
   import decode_pipe_pkg::*;
#(
   parameter int RW = DEF_RW,
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we,
   input  logic [RW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [RW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int N = 1 << RW;

   logic [DW-1:0] mem_q [N];
   logic [DW-1:0] mem_d [N];

   always_comb begin
      mem_d = mem_q;
      if (we)
         mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < N; i++)
            mem_q[i] <= DW'(lut_default(i));
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read sees the pre-edge contents, so a same-cycle write is not yet visible.
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - mode-dependent instruction decoder with a single registered output stage.
module decode_pipe
   import decode_pipe_pkg::*;
#(
   parameter int IW  = DEF_IW,
   parameter int OPW = DEF_OPW,
   parameter int RW  = DEF_RW,
   parameter int DW  = DEF_DW
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [IW-1:0]  mach_code,
   input  logic           flush,
   input  logic           lut_we,
   input  logic [RW-1:0]  lut_addr,
   input  logic [DW-1:0]  lut_wdata,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [OPW-1:0] opcode,
   output logic [RW-1:0]  reg1,
   output logic [RW-1:0]  reg2,
   output logic [DW-1:0]  immediate,
   output logic           is_imm,
   output logic           set_mode,
   output logic           mode_q
);

   generate
      if (IW != OPW + 2 * RW - 2) begin : g_bad_params
         $error("decode_pipe: IW must equal OPW + 2*RW - 2");
      end
   endgenerate

   localparam int IMM_OPW = IW - 2 * RW;

   mode_e          cur_mode_q, cur_mode_d;
   logic           out_valid_q, out_valid_d;
   logic [OPW-1:0] opcode_q, opcode_d;
   logic [RW-1:0]  reg1_q, reg1_d;
   logic [RW-1:0]  reg2_q, reg2_d;
   logic [DW-1:0]  imm_q, imm_d;
   logic           is_imm_q, is_imm_d;
   logic           set_mode_q, set_mode_d;

   logic [OPW-1:0] dec_opcode;
   logic [RW-1:0]  dec_reg1;
   logic [RW-1:0]  dec_reg2;
   logic [DW-1:0]  dec_imm;
   logic           dec_is_imm;
   logic           dec_set_mode;
   logic [DW-1:0]  lut_rdata;
   logic           accept;

   imm_lut #(
      .RW (RW),
      .DW (DW)
   ) u_imm_lut (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (lut_we),
      .waddr   (lut_addr),
      .wdata   (lut_wdata),
      .raddr   (mach_code[RW-1:0]),
      .rdata   (lut_rdata)
   );

   // Reg-reg form packs two narrow register fields under a wide opcode; reg-imm trades opcode bits for full ones.
   always_comb begin
      dec_opcode = '0;
      dec_reg1   = '0;
      dec_reg2   = '0;
      dec_imm    = '0;
      dec_is_imm = 1'b0;
      if (cur_mode_q == MODE_REG) begin
         dec_opcode = mach_code[IW-1 -: OPW];
         dec_reg1   = {1'b0, mach_code[2*RW-3 : RW-1]};
         dec_reg2   = {1'b0, mach_code[RW-2 : 0]};
      end else begin
         dec_opcode = {{(OPW - IMM_OPW){1'b0}}, mach_code[IW-1 : 2*RW]};
         dec_reg1   = mach_code[2*RW-1 : RW];
         dec_reg2   = mach_code[RW-1 : 0];
         dec_imm    = lut_rdata;
         dec_is_imm = 1'b1;
      end
   end

   assign dec_set_mode = (dec_opcode == OPW'(OP_SETMODE));
   assign in_ready     = !out_valid_q || out_ready;
   assign accept       = in_valid && in_ready && !flush;

   always_comb begin
      cur_mode_d  = cur_mode_q;
      out_valid_d = out_valid_q;
      opcode_d    = opcode_q;
      reg1_d      = reg1_q;
      reg2_d      = reg2_q;
      imm_d       = imm_q;
      is_imm_d    = is_imm_q;
      set_mode_d  = set_mode_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         opcode_d    = dec_opcode;
         reg1_d      = dec_reg1;
         reg2_d      = dec_reg2;
         imm_d       = dec_imm;
         is_imm_d    = dec_is_imm;
         set_mode_d  = dec_set_mode;
         if (dec_set_mode)
            cur_mode_d = (cur_mode_q == MODE_REG) ? MODE_IMM : MODE_REG;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_mode_q  <= MODE_REG;
         out_valid_q <= 1'b0;
         opcode_q    <= '0;
         reg1_q      <= '0;
         reg2_q      <= '0;
         imm_q       <= '0;
         is_imm_q    <= 1'b0;
         set_mode_q  <= 1'b0;
      end else begin
         cur_mode_q  <= cur_mode_d;
         out_valid_q <= out_valid_d;
         opcode_q    <= opcode_d;
         reg1_q      <= reg1_d;
         reg2_q      <= reg2_d;
         imm_q       <= imm_d;
         is_imm_q    <= is_imm_d;
         set_mode_q  <= set_mode_d;
      end
   end

   assign out_valid = out_valid_q;
   assign opcode    = opcode_q;
   assign reg1      = reg1_q;
   assign reg2      = reg2_q;
   assign immediate = imm_q;
   assign is_imm    = is_imm_q;
   assign set_mode  = set_mode_q;
   assign mode_q    = (cur_mode_q == MODE_IMM);

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - scoreboard bench for decode_pipe with a field-arithmetic reference model.
module tb_decode_pipe;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] mach_code;
   logic       flush;
   logic       lut_we;
   logic [2:0] lut_addr;
   logic [7:0] lut_wdata;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] opcode;
   logic [2:0] reg1;
   logic [2:0] reg2;
   logic [7:0] immediate;
   logic       is_imm;
   logic       set_mode;
   logic       mode_q;

   decode_pipe dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mach_code (mach_code),
      .flush     (flush),
      .lut_we    (lut_we),
      .lut_addr  (lut_addr),
      .lut_wdata (lut_wdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .opcode    (opcode),
      .reg1      (reg1),
      .reg2      (reg2),
      .immediate (immediate),
      .is_imm    (is_imm),
      .set_mode  (set_mode),
      .mode_q    (mode_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      int op;
      int r1;
      int r2;
      int imm;
      int ii;
      int sm;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   int   m_mode;
   int   m_ov;
   int   m_lut [8];

   task automatic chk(input string nm, input int got, input int req);
      tests++;
      if (got != req) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", nm, got, req);
      end
   endtask

   task automatic model_reset();
      int defs [8] = '{0, 1, 4, 8, 16, 32, 64, 127};
      m_mode = 0;
      m_ov   = 0;
      for (int i = 0; i < 8; i++) m_lut[i] = defs[i];
      exp_q.delete();
   endtask

   function automatic exp_t model_decode(input int code);
      exp_t e;
      if (m_mode == 0) begin
         e.op  = code / 16;
         e.r1  = (code / 4) % 4;
         e.r2  = code % 4;
         e.imm = 0;
         e.ii  = 0;
      end else begin
         e.op  = code / 64;
         e.r1  = (code / 8) % 8;
         e.r2  = code % 8;
         e.imm = m_lut[e.r2];
         e.ii  = 1;
      end
      e.sm = (e.op == 0) ? 1 : 0;
      return e;
   endfunction

   // Called just after a rising edge; returns just after the next rising edge.
   task automatic cycle(input int iv, input int code, input int ordy, input int fl,
                        input int we, input int wa, input int wd);
      int   exp_rdy;
      int   acc;
      exp_t e;
      in_valid  = iv[0];
      mach_code = code[8:0];
      out_ready = ordy[0];
      flush     = fl[0];
      lut_we    = we[0];
      lut_addr  = wa[2:0];
      lut_wdata = wd[7:0];
      #1;
      exp_rdy = (m_ov == 0 || ordy != 0) ? 1 : 0;
      chk("in_ready", int'(in_ready), exp_rdy);
      acc = (iv != 0 && exp_rdy != 0 && fl == 0) ? 1 : 0;
      e   = model_decode(code);
      @(posedge clk);
      if (fl != 0) begin
         if (m_ov != 0) void'(exp_q.pop_front());
         m_ov = 0;
      end else if (acc != 0) begin
         exp_q.push_back(e);
         m_ov = 1;
         if (e.sm != 0) m_mode = 1 - m_mode;
      end else if (ordy != 0) begin
         m_ov = 0;
      end
      if (we != 0) m_lut[wa % 8] = wd % 256;
      #1;
      chk("out_valid", int'(out_valid), m_ov);
      chk("mode_q", int'(mode_q), m_mode);
   endtask

   task automatic check_reset_outputs();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_mode_q", int'(mode_q), 0);
      chk("rst_opcode", int'(opcode), 0);
      chk("rst_reg1", int'(reg1), 0);
      chk("rst_reg2", int'(reg2), 0);
      chk("rst_immediate", int'(immediate), 0);
      chk("rst_is_imm", int'(is_imm), 0);
      chk("rst_set_mode", int'(set_mode), 0);
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      flush    = 1'b0;
      lut_we   = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      chk("in_ready_after_reset", int'(in_ready), 1);
   endtask

   // Monitor: the queue front is always the output currently held by the DUT.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && out_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got out_valid=1 opcode=%0d required no pending output", opcode);
         end else begin
            e = exp_q[0];
            chk("opcode", int'(opcode), e.op);
            chk("reg1", int'(reg1), e.r1);
            chk("reg2", int'(reg2), e.r2);
            chk("immediate", int'(immediate), e.imm);
            chk("is_imm", int'(is_imm), e.ii);
            chk("set_mode", int'(set_mode), e.sm);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int iv, code, ordy, fl, we, wa, wd;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      mach_code = '0;
      flush     = 1'b0;
      lut_we    = 1'b0;
      lut_addr  = '0;
      lut_wdata = '0;
      out_ready = 1'b1;
      model_reset();
      #2;
      check_reset_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      chk("in_ready_after_reset", int'(in_ready), 1);

      // Basic reg-reg decode, then mode switch and reg-imm decode.
      cycle(1, 9'b00011_01_10, 1, 0, 0, 0, 0);
      cycle(1, 9'b00000_00_00, 1, 0, 0, 0, 0);
      cycle(1, 9'b010_011_101, 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);

      // Backpressure: first held three cycles, second accepted only once ready returns.
      cycle(1, 9'b011_010_001, 1, 0, 0, 0, 0);
      cycle(1, 9'b100_101_110, 0, 0, 0, 0, 0);
      cycle(1, 9'b100_101_110, 0, 0, 0, 0, 0);
      cycle(1, 9'b100_101_110, 0, 0, 0, 0, 0);
      cycle(1, 9'b100_101_110, 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);

      // Same-cycle LUT write sees old value; next access sees new one.
      cycle(1, 9'b001_000_111, 1, 0, 1, 7, 200);
      cycle(1, 9'b001_001_111, 1, 0, 0, 0, 0);

      // Flush with a held output and an offered mode-switch instruction.
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(1, 9'b000_000_000, 0, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);

      // Reset mid-stream in mode 1 with a rewritten entry.
      cycle(0, 0, 1, 0, 1, 2, 99);
      cycle(1, 9'b001_000_010, 0, 0, 0, 0, 0);
      do_reset();
      cycle(1, 9'b00000_00_00, 1, 0, 0, 0, 0);
      cycle(1, 9'b001_000_010, 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);

      for (int n = 0; n < 2000; n++) begin
         iv   = ($urandom_range(0, 3) != 0) ? 1 : 0;
         code = $urandom_range(0, 511);
         if ($urandom_range(0, 7) == 0) code = code % 64;
         ordy = ($urandom_range(0, 9) < 7) ? 1 : 0;
         fl   = ($urandom_range(0, 19) == 0) ? 1 : 0;
         if (fl != 0) ordy = 0;
         we   = ($urandom_range(0, 4) == 0) ? 1 : 0;
         wa   = $urandom_range(0, 7);
         wd   = $urandom_range(0, 255);
         cycle(iv, code, ordy, fl, we, wa, wd);
         if (n == 1000) do_reset();
      end

      repeat (4) cycle(0, 0, 1, 0, 0, 0, 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
